uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter sitting downstream of the RISC-V core: the core (or its future memory-mapped I/O decoder) pushes bytes through a valid/ready write port, and the block serialises them onto the board TXD pin. An internal FIFO decouples the slow serial line from the core, so short bursts of writes do not stall the CPU. The block runs in the core's clock domain, on the divided `clk` and `resetn` produced by the clock/reset gearbox.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and bit-period arithmetic.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per serial bit, rounded to the nearest integer.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read and an explicit occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    // Full and empty come from the count, so pointers may wrap freely.
    assign do_push = push && (level_q != LVL_FULL);
    assign do_pop  = pop  && (level_q != '0);
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Next pointer and occupancy values.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the count makes stale entries unreadable and it can map to RAM.
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: write port into a FIFO, FSM serialises bytes onto tx.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          tx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic             fifo_push, fifo_pop, fifo_empty, bit_end;
    logic [7:0]       fifo_dout;
    logic [LVL_W-1:0] fifo_level;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .din    (wr_data),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .level  (fifo_level)
    );

    assign wr_ready   = (fifo_level != LVL_FULL);
    assign fifo_push  = wr_valid && wr_ready;
    assign fifo_empty = (fifo_level == '0);
    assign bit_end    = (cnt_q == CNT_LAST);
    assign level      = fifo_level;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign tx         = tx_q;

    // Frame sequencing, bit timing, and the registered line level for the next cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // FSM, baud counter, shift register and line register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: queue/frame-time model compared every cycle, plus directed literal checks.
module tb_uart_tx_fifo;

    localparam int TB_CPB   = 4;            // 1 MHz / 250 kBd
    localparam int TB_DEPTH = 4;
    localparam int FRAME    = 10 * TB_CPB;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] level;
    logic       busy;
    logic       tx;

    logic       d_resetn;
    logic [7:0] d_wr_data;
    logic       d_wr_valid;
    logic       d_wr_ready;
    logic [3:0] d_level;
    logic       d_busy;
    logic       d_tx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (250_000),
        .FIFO_DEPTH (TB_DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .level    (level),
        .busy     (busy),
        .tx       (tx)
    );

    uart_tx_fifo dut_def (
        .clk      (clk),
        .resetn   (d_resetn),
        .wr_data  (d_wr_data),
        .wr_valid (d_wr_valid),
        .wr_ready (d_wr_ready),
        .level    (d_level),
        .busy     (d_busy),
        .tx       (d_tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    logic [7:0] m_byte;
    bit         m_active    = 1'b0;
    int         m_t         = 0;
    bit         model_valid = 1'b0;
    bit         dec_abort   = 1'b0;
    bit         pop_now, accept;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            mq.delete();
            m_active    = 1'b0;
            m_t         = 0;
            model_valid = 1'b1;
            dec_abort   = 1'b1;
        end else if (model_valid) begin
            pop_now = (mq.size() > 0) && (!m_active || m_t == FRAME - 1);
            accept  = wr_valid && (mq.size() < TB_DEPTH);
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) m_active = 1'b0;
            end
            if (pop_now) begin
                m_byte   = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (accept) mq.push_back(wr_data);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("m_tx", tx, m_active ? frame_bit(m_byte, m_t / TB_CPB) : 1'b1);
            check("m_level", level, mq.size());
            check("m_wr_ready", wr_ready, mq.size() != TB_DEPTH);
            check("m_busy", busy, m_active || (mq.size() != 0));
        end
    end

    // ---------------- line decoder ----------------
    logic [7:0] rx_q[$];
    logic [7:0] dec_byte;
    bit         in_frame = 1'b0;
    int         dec_cnt  = 0;

    always @(negedge clk) begin
        if (dec_abort) begin
            in_frame  = 1'b0;
            dec_abort = 1'b0;
        end else if (!in_frame) begin
            if (model_valid && tx === 1'b0) begin
                in_frame = 1'b1;
                dec_cnt  = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt % TB_CPB == 1 && dec_cnt / TB_CPB >= 1 && dec_cnt / TB_CPB <= 8)
                dec_byte[dec_cnt / TB_CPB - 1] = tx;
            if (dec_cnt == 9 * TB_CPB + 1) begin
                rx_q.push_back(dec_byte);
                in_frame = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_byte(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp);
        if (rx_q.size() > 0) check(name, rx_q.pop_front(), exp);
        else                 check(name, rx_q.size(), 1);
    endtask

    task automatic wait_idle(input string name, input int bound, output int cyc, output int maxl);
        cyc  = 0;
        maxl = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (int'(level) > maxl) maxl = int'(level);
        end
        check(name, busy, 1'b0);
    endtask

    logic [0:9] exp_a5;
    int cyc, maxl, busy_high;
    int changes[$];
    int busy_fall;
    logic prev;

    initial begin
        resetn     = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        d_resetn   = 1'b0;
        d_wr_valid = 1'b0;
        d_wr_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_tx", tx, 1'b1);
        check("rst_level", level, 3'd0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_def_tx", d_tx, 1'b1);
        resetn   = 1'b1;
        d_resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop.
        exp_a5 = 10'b0101001011;
        push_byte(8'hA5);
        check("single_level", level, 3'd1);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check("single_tx", tx, exp_a5[(k-1)/TB_CPB]);
        end
        check("single_busy_last", busy, 1'b1);
        @(negedge clk);
        check("single_busy_fall", busy, 1'b0);
        expect_rx("single_rx", 8'hA5);

        // Burst of four bytes on consecutive cycles.
        busy_high = 0;
        maxl      = 0;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'(i + 1));
            check("burst_ready", wr_ready, 1'b1);
            if (busy) busy_high++;
            if (int'(level) > maxl) maxl = int'(level);
        end
        begin
            int m2;
            wait_idle("burst_idle", 400, cyc, m2);
            if (m2 > maxl) maxl = m2;
        end
        check("burst_max_level", maxl, 3);
        check("burst_busy_cycles", busy_high + cyc, 4 * FRAME + 1);
        for (int i = 0; i < 4; i++) expect_rx("burst_rx", 8'(i + 1));

        // Overflow while a frame is in flight.
        push_byte(8'h10);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h11 + 8'(i));
            if (i == 3) begin
                check("ovf_level_full", level, 3'd4);
                check("ovf_ready_low", wr_ready, 1'b0);
            end
            if (i == 4) check("ovf_drop_level", level, 3'd4);
        end
        wait_idle("ovf_idle", 600, cyc, maxl);
        for (int i = 0; i < 5; i++) expect_rx("ovf_rx", 8'h10 + 8'(i));
        check("ovf_frames", rx_q.size(), 0);

        // Simultaneous push and pop at the end of a stop bit.
        push_byte(8'h21);
        push_byte(8'h22);
        push_byte(8'h23);
        repeat (FRAME - 2) @(negedge clk);
        check("pp_level_before", level, 3'd2);
        push_byte(8'h7E);
        check("pp_level_after", level, 3'd2);
        wait_idle("pp_idle", 600, cyc, maxl);
        expect_rx("pp_rx", 8'h21);
        expect_rx("pp_rx", 8'h22);
        expect_rx("pp_rx", 8'h23);
        expect_rx("pp_rx", 8'h7E);

        // Reset during DATA bit 3 with two bytes queued.
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        repeat (15) @(negedge clk);
        check("mrst_level_before", level, 3'd2);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("mrst_tx", tx, 1'b1);
        check("mrst_level", level, 3'd0);
        check("mrst_busy", busy, 1'b0);
        repeat (200) @(negedge clk);
        check("mrst_no_frames", rx_q.size(), 0);
        check("mrst_tx_idle", tx, 1'b1);

        // Default parameters: 0x55 toggles every bit; each period must be 87 cycles.
        d_wr_valid = 1'b1;
        d_wr_data  = 8'h55;
        @(negedge clk);
        d_wr_valid = 1'b0;
        prev      = d_tx;
        busy_fall = -1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (d_tx !== prev) begin
                changes.push_back(k);
                prev = d_tx;
            end
            if (!d_busy) begin
                busy_fall = k;
                break;
            end
        end
        check("def_idle", d_busy, 1'b0);
        check("def_changes", changes.size(), 10);
        if (changes.size() == 10) begin
            check("def_first_fall", changes[0], 1);
            for (int i = 1; i < 10; i++) check("def_bit_period", changes[i] - changes[i-1], 87);
            check("def_stop_period", busy_fall - changes[9], 87);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
